// File: rtl/rf_writeback_arb_if.sv
// Writeback bus between the execute/memory stages and the register-file writer.
// Groups ALU results, load results, scoreboard set and the file write port.
interface rf_writeback_arb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  localparam int NREG = 1 << AW;

  logic            io_alu_valid;
  logic            io_alu_ready;
  logic [AW-1:0]   io_alu_wa;
  logic [XLEN-1:0] io_alu_wd;

  logic            io_mem_valid;
  logic            io_mem_ready;
  logic [AW-1:0]   io_mem_wa;
  logic [XLEN-1:0] io_mem_wd;

  logic            io_sb_set;
  logic [AW-1:0]   io_sb_wa;
  logic [NREG-1:0] io_busy;

  logic            io_rf_wen;
  logic [AW-1:0]   io_rf_wa;
  logic [XLEN-1:0] io_rf_wd;

  // Producer side: execute/memory stages and issue logic.
  modport master (
    output io_alu_valid, io_alu_wa, io_alu_wd,
    output io_mem_valid, io_mem_wa, io_mem_wd,
    output io_sb_set, io_sb_wa,
    input  io_alu_ready, io_mem_ready, io_busy,
    input  io_rf_wen, io_rf_wa, io_rf_wd
  );

  // Arbiter side.
  modport slave (
    input  io_alu_valid, io_alu_wa, io_alu_wd,
    input  io_mem_valid, io_mem_wa, io_mem_wd,
    input  io_sb_set, io_sb_wa,
    output io_alu_ready, io_mem_ready, io_busy,
    output io_rf_wen, io_rf_wa, io_rf_wd
  );
endinterface

// File: rtl/rf_writeback_arb.sv
// Register-file write-port arbiter: ALU results have priority, load results are
// buffered in a small FIFO that forces a pop when full; tracks pending loads.
module rf_writeback_arb #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int MEMQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  rf_writeback_arb_if.slave bus
);
  localparam int PW   = $clog2(MEMQ_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_wa_q, rf_wa_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  logic [AW-1:0]   q_wa_q [MEMQ_DEPTH];
  logic [XLEN-1:0] q_wd_q [MEMQ_DEPTH];

  logic            full, enq, pop, sel_alu, sel;
  logic [AW-1:0]   head_wa, sel_wa;
  logic [XLEN-1:0] head_wd, sel_wd;

  assign full    = (count_q == CW'(MEMQ_DEPTH));
  assign enq     = bus.io_mem_valid && !full;
  // A full queue steals the port from the ALU so loads can never starve.
  assign sel_alu = !full && bus.io_alu_valid;
  assign pop     = full || (!bus.io_alu_valid && (count_q != '0));
  assign sel     = sel_alu || pop;

  assign head_wa = q_wa_q[rd_ptr_q];
  assign head_wd = q_wd_q[rd_ptr_q];
  assign sel_wa  = sel_alu ? bus.io_alu_wa : head_wa;
  assign sel_wd  = sel_alu ? bus.io_alu_wd : head_wd;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set is applied after clear so a re-issued load to the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_wa] = 1'b0;
    if (bus.io_sb_set && (bus.io_sb_wa != '0)) busy_d[bus.io_sb_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rf_wen_d = sel && (sel_wa != '0);
    rf_wa_d  = sel ? sel_wa : rf_wa_q;
    rf_wd_d  = sel ? sel_wd : rf_wd_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      busy_q   <= '0;
      rf_wen_q <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      busy_q   <= busy_d;
      rf_wen_q <= rf_wen_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // NOTE: queue storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_wa_q[wr_ptr_q] <= bus.io_mem_wa;
      q_wd_q[wr_ptr_q] <= bus.io_mem_wd;
    end
  end

  assign bus.io_alu_ready = !full;
  assign bus.io_mem_ready = !full;
  assign bus.io_busy      = busy_q;
  assign bus.io_rf_wen    = rf_wen_q;
  assign bus.io_rf_wa     = rf_wa_q;
  assign bus.io_rf_wd     = rf_wd_q;
endmodule

// File: tb/tb_rf_writeback_arb.sv
// Directed bench for rf_writeback_arb: reset, ALU path, scoreboard, forced load
// pops when the queue fills, x0 handling, same-cycle set/clear and mid-run reset.
module tb_rf_writeback_arb;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  rf_writeback_arb_if #(.XLEN(32), .AW(5)) bus ();

  rf_writeback_arb #(.XLEN(32), .AW(5), .MEMQ_DEPTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.io_alu_valid = v;
    bus.io_alu_wa    = wa;
    bus.io_alu_wd    = wd;
  endtask

  task automatic mem(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.io_mem_valid = v;
    bus.io_mem_wa    = wa;
    bus.io_mem_wd    = wd;
  endtask

  task automatic sb(input logic s, input logic [4:0] wa);
    bus.io_sb_set = s;
    bus.io_sb_wa  = wa;
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] wa, input logic [31:0] wd);
    check({tag, "_wen"}, 64'(bus.io_rf_wen), 64'd1);
    check({tag, "_wa"},  64'(bus.io_rf_wa),  64'(wa));
    check({tag, "_wd"},  64'(bus.io_rf_wd),  64'(wd));
  endtask

  initial begin
    reset = 1'b1;
    alu(1'b1, 5'd1, 32'h11);
    mem(1'b0, 5'd0, 32'h0);
    sb(1'b0, 5'd0);

    // Reset held two cycles with an ALU result waiting.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_wen",   64'(bus.io_rf_wen),   64'd0);
      check("rst_busy",  64'(bus.io_busy),     64'd0);
      check("rst_mrdy",  64'(bus.io_mem_ready), 64'd1);
    end
    reset = 1'b0;
    #1 check("post_rst_ardy", 64'(bus.io_alu_ready), 64'd1);
    tick();
    expect_wr("first", 5'd1, 32'h11);

    // ALU only.
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("alu_ready", 64'(bus.io_alu_ready), 64'd1);
    tick();
    expect_wr("alu", 5'd5, 32'hDEADBEEF);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    check("alu_idle_wen", 64'(bus.io_rf_wen), 64'd0);
    check("alu_hold_wa",  64'(bus.io_rf_wa),  64'd5);

    // Scoreboard round trip on x7.
    sb(1'b1, 5'd7);
    tick();
    sb(1'b0, 5'd0);
    check("sb_set7", 64'(bus.io_busy), 64'h80);
    mem(1'b1, 5'd7, 32'h1234);
    #1 check("sb_mrdy", 64'(bus.io_mem_ready), 64'd1);
    tick();
    mem(1'b0, 5'd0, 32'h0);
    check("sb_enq_wen",  64'(bus.io_rf_wen), 64'd0);
    check("sb_enq_busy", 64'(bus.io_busy),   64'h80);
    tick();
    expect_wr("ld7", 5'd7, 32'h1234);
    check("sb_clr7", 64'(bus.io_busy), 64'd0);
    tick();
    check("ld7_after", 64'(bus.io_rf_wen), 64'd0);

    // Starvation guard: ALU valid every cycle while loads fill the queue.
    alu(1'b1, 5'd10, 32'hA0);
    mem(1'b1, 5'd3, 32'h33);
    #1 check("st_a_ardy", 64'(bus.io_alu_ready), 64'd1);
    tick();
    expect_wr("st_a", 5'd10, 32'hA0);
    alu(1'b1, 5'd11, 32'hA1);
    mem(1'b1, 5'd4, 32'h44);
    #1 check("st_b_mrdy", 64'(bus.io_mem_ready), 64'd1);
    tick();
    expect_wr("st_b", 5'd11, 32'hA1);
    alu(1'b1, 5'd12, 32'hA2);
    mem(1'b0, 5'd0, 32'h0);
    #1;
    check("st_full_ardy", 64'(bus.io_alu_ready), 64'd0);
    check("st_full_mrdy", 64'(bus.io_mem_ready), 64'd0);
    tick();
    expect_wr("st_ld3", 5'd3, 32'h33);
    mem(1'b1, 5'd6, 32'h66);
    #1 check("st_d_ardy", 64'(bus.io_alu_ready), 64'd1);
    tick();
    expect_wr("st_alu12", 5'd12, 32'hA2);
    alu(1'b1, 5'd13, 32'hA3);
    mem(1'b0, 5'd0, 32'h0);
    #1 check("st_e_ardy", 64'(bus.io_alu_ready), 64'd0);
    tick();
    expect_wr("st_ld4", 5'd4, 32'h44);
    tick();
    expect_wr("st_alu13", 5'd13, 32'hA3);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("st_ld6", 5'd6, 32'h66);
    tick();
    check("st_drain", 64'(bus.io_rf_wen), 64'd0);

    // x0: consumed but never written, never marked busy.
    alu(1'b1, 5'd0, 32'hFFFFFFFF);
    sb(1'b1, 5'd0);
    #1 check("x0_ardy", 64'(bus.io_alu_ready), 64'd1);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    sb(1'b0, 5'd0);
    check("x0_wen",  64'(bus.io_rf_wen), 64'd0);
    check("x0_wd",   64'(bus.io_rf_wd),  64'hFFFFFFFF);
    check("x0_busy", 64'(bus.io_busy),   64'd0);

    // Same-cycle set and clear on x9.
    sb(1'b1, 5'd9);
    tick();
    sb(1'b0, 5'd0);
    mem(1'b1, 5'd9, 32'h99);
    tick();
    mem(1'b0, 5'd0, 32'h0);
    check("sc_busy_pre", 64'(bus.io_busy), 64'h200);
    sb(1'b1, 5'd9);
    tick();
    sb(1'b0, 5'd0);
    expect_wr("sc_ld1", 5'd9, 32'h99);
    check("sc_set_wins", 64'(bus.io_busy), 64'h200);
    mem(1'b1, 5'd9, 32'h98);
    tick();
    mem(1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("sc_ld2", 5'd9, 32'h98);
    check("sc_clear", 64'(bus.io_busy), 64'd0);

    // Reset mid-operation discards queued loads and pending bits.
    sb(1'b1, 5'd2);
    mem(1'b1, 5'd2, 32'h22);
    tick();
    sb(1'b0, 5'd0);
    mem(1'b0, 5'd0, 32'h0);
    check("mr_busy_pre", 64'(bus.io_busy), 64'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_busy",  64'(bus.io_busy),      64'd0);
    check("mr_mrdy",  64'(bus.io_mem_ready), 64'd1);
    tick();
    check("mr_nowr", 64'(bus.io_rf_wen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
